// File: rtl/adc_i2c_responder_if.sv
// adc_i2c_responder_if: open-drain I2C pair as seen by the ADC responder
interface adc_i2c_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;
    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/adc_i2c_responder.sv
// adc_i2c_responder: I2C target emulating a 12-bit ADC with an 8-bit config register
module adc_i2c_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h28,
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    adc_i2c_responder_if.slave bus,
    input  logic [11:0]        sample_data,
    input  logic               sample_valid,
    output logic [7:0]         config_reg,
    output logic               config_wr,
    output logic               addr_match,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
    state_t state_q, state_d;
    logic [2:0] scl_q, scl_d, sda_q, sda_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, cfg_q, cfg_d;
    logic [11:0] snap_q, snap_d, hold_q, hold_d;
    logic rw_q, rw_d, sel_q, sel_d, oe_q, oe_d, wr_q, wr_d, match_q, match_d;
    logic scl_rise, scl_fall, start, stop;
    logic [7:0] byte_in;
    logic [11:0] fresh;
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start = scl_q[1] & sda_q[2] & ~sda_q[1];
    assign stop = scl_q[1] & ~sda_q[2] & sda_q[1];
    assign byte_in = {rx_q[6:0], sda_q[1]};
    assign fresh = sample_valid ? sample_data : hold_q;
    always_comb begin
        scl_d = {scl_q[1:0], bus.scl_in};
        sda_d = {sda_q[1:0], bus.sda_in};
        hold_d = fresh;
        state_d = state_q;
        cnt_d = cnt_q;
        rx_d = rx_q;
        tx_d = tx_q;
        rw_d = rw_q;
        sel_d = sel_q;
        snap_d = snap_q;
        cfg_d = cfg_q;
        wr_d = 1'b0;
        match_d = 1'b0;
        oe_d = oe_q;
        if (scl_fall)
            oe_d = (state_q == ADDR_ACK || state_q == WR_ACK) ? 1'b1 : (state_q == RD_DATA) ? ~tx_q[7] : 1'b0;
        if (scl_rise) begin
            case (state_q)
                IDLE, IGNORE: ;
                ADDR: begin
                    rx_d = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_d = sda_q[1];
                        match_d = byte_in[7:1] == DEV_ADDR;
                        state_d = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: begin
                    cnt_d = 4'd0;
                    state_d = rw_q ? RD_DATA : WR_DATA;
                    if (rw_q) begin
                        snap_d = fresh;
                        sel_d = 1'b0;
                        tx_d = {4'b0000, fresh[11:8]};
                    end
                end
                WR_DATA: begin
                    rx_d = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cfg_d = byte_in;
                        wr_d = 1'b1;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    cnt_d = 4'd0;
                    state_d = WR_DATA;
                end
                RD_DATA: begin
                    tx_d = {tx_q[6:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd7) ? RD_ACK : RD_DATA;
                end
                RD_ACK: begin
                    cnt_d = 4'd0;
                    state_d = sda_q[1] ? IGNORE : RD_DATA;
                    if (!sda_q[1]) begin
                        sel_d = ~sel_q;
                        snap_d = sel_q ? fresh : snap_q;
                        tx_d = sel_q ? {4'b0000, fresh[11:8]} : snap_q[7:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (start) begin
            state_d = ADDR;
            cnt_d = 4'd0;
            oe_d = 1'b0;
        end
        if (stop) begin
            state_d = IDLE;
            oe_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scl_q <= 3'b111;
            sda_q <= 3'b111;
            cnt_q <= 4'd0;
            rx_q <= 8'h00;
            tx_q <= 8'h00;
            cfg_q <= CFG_RESET;
            snap_q <= 12'h000;
            hold_q <= 12'h000;
            rw_q <= 1'b0;
            sel_q <= 1'b0;
            oe_q <= 1'b0;
            wr_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_q <= scl_d;
            sda_q <= sda_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            tx_q <= tx_d;
            cfg_q <= cfg_d;
            snap_q <= snap_d;
            hold_q <= hold_d;
            rw_q <= rw_d;
            sel_q <= sel_d;
            oe_q <= oe_d;
            wr_q <= wr_d;
            match_q <= match_d;
        end
    end
    assign bus.sda_oe = oe_q;
    assign config_reg = cfg_q;
    assign config_wr = wr_q;
    assign addr_match = match_q;
    assign busy = state_q != IDLE;
endmodule
